// File: rtl/pio_access_arbiter.sv
// Two-master round-robin arbiter in front of a single 8-bit PIO Avalon slave.
// Grants are registered (no zero-wait path); a master may lock the grant for atomic sequences.
module pio_access_arbiter #(
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_chipselect,
   input  logic              m0_write_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_lock,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_chipselect,
   input  logic              m1_write_n,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_lock,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              s_chipselect,
   output logic              s_write_n,
   output logic [ADDR_W-1:0] s_address,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t             state, state_next, eff_state;
   logic               rr_ptr, rr_ptr_next;
   logic [CNT_W-1:0]   lock_cnt, lock_cnt_next, cnt_inc;
   logic               rd_pending, rd_pending_next;
   logic               rd_owner, rd_owner_next;

   logic               own_id;
   logic               own_cs, own_wn, own_lock, other_cs;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_data;

   // Reset forces idle-looking outputs in the same cycle, so nothing can issue while it is held.
   assign eff_state = reset ? IDLE : state;

   assign own_id   = (eff_state == OWN1);
   assign own_cs   = own_id ? m1_chipselect : m0_chipselect;
   assign own_wn   = own_id ? m1_write_n    : m0_write_n;
   assign own_lock = own_id ? m1_lock       : m0_lock;
   assign own_addr = own_id ? m1_address    : m0_address;
   assign own_data = own_id ? m1_writedata  : m0_writedata;
   assign other_cs = own_id ? m0_chipselect : m1_chipselect;

   // Saturates so a lock held with nobody waiting cannot wrap back below the limit.
   assign cnt_inc = (lock_cnt == LOCK_LIM) ? lock_cnt : lock_cnt + CNT_W'(1);

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = rd_pending && !rd_owner;
   assign m1_readdatavalid = rd_pending &&  rd_owner;

   always_comb begin
      state_next      = eff_state;
      rr_ptr_next     = rr_ptr;
      lock_cnt_next   = lock_cnt;
      rd_pending_next = 1'b0;
      rd_owner_next   = rd_owner;
      m0_waitrequest  = m0_chipselect;
      m1_waitrequest  = m1_chipselect;
      s_chipselect    = 1'b0;
      s_write_n       = 1'b1;
      s_address       = '0;
      s_writedata     = '0;
      case (eff_state)
         IDLE: begin
            lock_cnt_next = '0;
            if (m0_chipselect && m1_chipselect)
               state_next = rr_ptr ? OWN1 : OWN0;
            else if (m0_chipselect)
               state_next = OWN0;
            else if (m1_chipselect)
               state_next = OWN1;
         end
         OWN0, OWN1: begin
            if (own_id)
               m1_waitrequest = 1'b0;
            else
               m0_waitrequest = 1'b0;
            s_chipselect = own_cs;
            s_write_n    = own_wn;
            s_address    = own_addr;
            s_writedata  = own_data;
            if (own_cs) begin
               if (own_wn) begin
                  rd_pending_next = 1'b1;
                  rd_owner_next   = own_id;
               end
               // A lock is broken silently once the other master has waited LOCK_MAX transfers.
               if (own_lock && !(cnt_inc == LOCK_LIM && other_cs)) begin
                  lock_cnt_next = cnt_inc;
               end else begin
                  state_next    = IDLE;
                  rr_ptr_next   = ~own_id;
                  lock_cnt_next = '0;
               end
            end else if (!own_lock) begin
               state_next    = IDLE;
               lock_cnt_next = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         lock_cnt   <= '0;
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         state      <= state_next;
         rr_ptr     <= rr_ptr_next;
         lock_cnt   <= lock_cnt_next;
         rd_pending <= rd_pending_next;
         rd_owner   <= rd_owner_next;
      end
   end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Directed, table-driven bench for pio_access_arbiter: per-cycle vectors plus
// hand-written sequences for lock saturation and reset during a read.
module tb_pio_access_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_chipselect, m0_write_n, m0_lock;
   logic [2:0]  m0_address;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest, m0_readdatavalid;
   logic [31:0] m0_readdata;
   logic        m1_chipselect, m1_write_n, m1_lock;
   logic [2:0]  m1_address;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest, m1_readdatavalid;
   logic [31:0] m1_readdata;
   logic        s_chipselect, s_write_n;
   logic [2:0]  s_address;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   int errors = 0;
   int checks = 0;

   // ctl = {chipselect, write_n, lock}; ex = {wr0, wr1, rdv0, rdv1, s_cs, s_write_n}
   typedef struct {
      logic        rst;
      logic [2:0]  ctl0;
      logic [2:0]  a0;
      logic [31:0] d0;
      logic [2:0]  ctl1;
      logic [2:0]  a1;
      logic [31:0] d1;
      logic [31:0] srd;
      logic [5:0]  ex;
      logic [2:0]  ea;
      logic [31:0] ed;
   } vec_t;

   vec_t vecs[34];
   vec_t rstSeq[5];

   pio_access_arbiter #(.ADDR_W(3), .DATA_W(32), .LOCK_MAX(8)) dut (
      .clk(clk),
      .reset(reset),
      .m0_chipselect(m0_chipselect),
      .m0_write_n(m0_write_n),
      .m0_address(m0_address),
      .m0_writedata(m0_writedata),
      .m0_lock(m0_lock),
      .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_chipselect(m1_chipselect),
      .m1_write_n(m1_write_n),
      .m1_address(m1_address),
      .m1_writedata(m1_writedata),
      .m1_lock(m1_lock),
      .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_chipselect(s_chipselect),
      .s_write_n(s_write_n),
      .s_address(s_address),
      .s_writedata(s_writedata),
      .s_readdata(s_readdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset         = v.rst;
      m0_chipselect = v.ctl0[2];
      m0_write_n    = v.ctl0[1];
      m0_lock       = v.ctl0[0];
      m0_address    = v.a0;
      m0_writedata  = v.d0;
      m1_chipselect = v.ctl1[2];
      m1_write_n    = v.ctl1[1];
      m1_lock       = v.ctl1[0];
      m1_address    = v.a1;
      m1_writedata  = v.d1;
      s_readdata    = v.srd;
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      check({tag, "/m0_waitrequest"},   32'(m0_waitrequest),   32'(v.ex[5]));
      check({tag, "/m1_waitrequest"},   32'(m1_waitrequest),   32'(v.ex[4]));
      check({tag, "/m0_readdatavalid"}, 32'(m0_readdatavalid), 32'(v.ex[3]));
      check({tag, "/m1_readdatavalid"}, 32'(m1_readdatavalid), 32'(v.ex[2]));
      check({tag, "/s_chipselect"},     32'(s_chipselect),     32'(v.ex[1]));
      check({tag, "/m0_readdata"},      m0_readdata,           v.srd);
      check({tag, "/m1_readdata"},      m1_readdata,           v.srd);
      if (v.ex[1]) begin
         check({tag, "/s_write_n"},   32'(s_write_n), 32'(v.ex[0]));
         check({tag, "/s_address"},   32'(s_address), 32'(v.ea));
         check({tag, "/s_writedata"}, s_writedata,    v.ed);
      end
   endtask

   task automatic runVector(input vec_t v, input string tag);
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkOutput(v, tag);
   endtask

   initial begin
      vec_t idleVec;
      logic [2:0]  expAddr[13];
      logic [31:0] expData[13];
      int m1Sent;
      bit m0Done;
      int issues;

      // reset, m0 write addr1=0xFF, m0 read addr0
      vecs[0]  = '{1'b1, 3'b100, 3'd1, 32'hFF, 3'b000, 3'd0, 32'h0,  32'h0,  6'b100000, 3'd0, 32'h0};
      vecs[1]  = '{1'b0, 3'b100, 3'd1, 32'hFF, 3'b000, 3'd0, 32'h0,  32'h0,  6'b100000, 3'd0, 32'h0};
      vecs[2]  = '{1'b0, 3'b100, 3'd1, 32'hFF, 3'b000, 3'd0, 32'h0,  32'h0,  6'b000010, 3'd1, 32'hFF};
      vecs[3]  = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};
      vecs[4]  = '{1'b0, 3'b110, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b100000, 3'd0, 32'h0};
      vecs[5]  = '{1'b0, 3'b110, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000011, 3'd0, 32'h0};
      vecs[6]  = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h5A, 6'b001000, 3'd0, 32'h0};
      vecs[7]  = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};
      // both masters contend from reset: m0, m1, m0, m1
      vecs[8]  = '{1'b1, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};
      vecs[9]  = '{1'b0, 3'b100, 3'd0, 32'h11, 3'b100, 3'd2, 32'h22, 32'h0,  6'b110000, 3'd0, 32'h0};
      vecs[10] = '{1'b0, 3'b100, 3'd0, 32'h11, 3'b100, 3'd2, 32'h22, 32'h0,  6'b010010, 3'd0, 32'h11};
      vecs[11] = '{1'b0, 3'b100, 3'd0, 32'h33, 3'b100, 3'd2, 32'h22, 32'h0,  6'b110000, 3'd0, 32'h0};
      vecs[12] = '{1'b0, 3'b100, 3'd0, 32'h33, 3'b100, 3'd2, 32'h22, 32'h0,  6'b100010, 3'd2, 32'h22};
      vecs[13] = '{1'b0, 3'b100, 3'd0, 32'h33, 3'b100, 3'd3, 32'h44, 32'h0,  6'b110000, 3'd0, 32'h0};
      vecs[14] = '{1'b0, 3'b100, 3'd0, 32'h33, 3'b100, 3'd3, 32'h44, 32'h0,  6'b010010, 3'd0, 32'h33};
      vecs[15] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd3, 32'h44, 32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[16] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd3, 32'h44, 32'h0,  6'b000010, 3'd3, 32'h44};
      vecs[17] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};
      // m0 locked pair direction+data while m1 waits
      vecs[18] = '{1'b0, 3'b101, 3'd1, 32'h0F, 3'b100, 3'd4, 32'h55, 32'h0,  6'b110000, 3'd0, 32'h0};
      vecs[19] = '{1'b0, 3'b101, 3'd1, 32'h0F, 3'b100, 3'd4, 32'h55, 32'h0,  6'b010010, 3'd1, 32'h0F};
      vecs[20] = '{1'b0, 3'b100, 3'd0, 32'h03, 3'b100, 3'd4, 32'h55, 32'h0,  6'b010010, 3'd0, 32'h03};
      vecs[21] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd4, 32'h55, 32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[22] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd4, 32'h55, 32'h0,  6'b000010, 3'd4, 32'h55};
      // locked idle gap holds the grant, dropping lock releases it
      vecs[23] = '{1'b0, 3'b101, 3'd5, 32'h01, 3'b000, 3'd0, 32'h0,  32'h0,  6'b100000, 3'd0, 32'h0};
      vecs[24] = '{1'b0, 3'b101, 3'd5, 32'h01, 3'b000, 3'd0, 32'h0,  32'h0,  6'b000010, 3'd5, 32'h01};
      vecs[25] = '{1'b0, 3'b001, 3'd0, 32'h0,  3'b100, 3'd4, 32'h66, 32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[26] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd4, 32'h66, 32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[27] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd4, 32'h66, 32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[28] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b100, 3'd4, 32'h66, 32'h0,  6'b000010, 3'd4, 32'h66};
      vecs[29] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};
      // m1 read returns to m1 only
      vecs[30] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b110, 3'd0, 32'h0,  32'h0,  6'b010000, 3'd0, 32'h0};
      vecs[31] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b110, 3'd0, 32'h0,  32'h0,  6'b000011, 3'd0, 32'h0};
      vecs[32] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'hA5, 6'b000100, 3'd0, 32'h0};
      vecs[33] = '{1'b0, 3'b000, 3'd0, 32'h0,  3'b000, 3'd0, 32'h0,  32'h0,  6'b000000, 3'd0, 32'h0};

      // reset lands on the cycle m0 would issue a read
      rstSeq[0] = '{1'b0, 3'b110, 3'd2, 32'h0, 3'b000, 3'd0, 32'h0, 32'h0,  6'b100000, 3'd0, 32'h0};
      rstSeq[1] = '{1'b1, 3'b110, 3'd2, 32'h0, 3'b000, 3'd0, 32'h0, 32'h0,  6'b100000, 3'd0, 32'h0};
      rstSeq[2] = '{1'b0, 3'b110, 3'd2, 32'h0, 3'b000, 3'd0, 32'h0, 32'h0,  6'b100000, 3'd0, 32'h0};
      rstSeq[3] = '{1'b0, 3'b110, 3'd2, 32'h0, 3'b000, 3'd0, 32'h0, 32'h0,  6'b000011, 3'd2, 32'h0};
      rstSeq[4] = '{1'b0, 3'b000, 3'd0, 32'h0, 3'b000, 3'd0, 32'h0, 32'hC3, 6'b001000, 3'd0, 32'h0};

      idleVec = '{1'b1, 3'b000, 3'd0, 32'h0, 3'b000, 3'd0, 32'h0, 32'h0, 6'b000000, 3'd0, 32'h0};
      applyStimulus(idleVec);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 34; i++)
         runVector(vecs[i], $sformatf("vec%0d", i));

      // m1 locks 12 writes (addr0, data=index) while m0 waits with one write (addr1, 0x77)
      for (int i = 0; i < 8; i++) begin
         expAddr[i] = 3'd0;
         expData[i] = 32'(i);
      end
      expAddr[8] = 3'd1;
      expData[8] = 32'h77;
      for (int i = 9; i < 13; i++) begin
         expAddr[i] = 3'd0;
         expData[i] = 32'(i - 1);
      end
      m1Sent = 0;
      m0Done = 1'b0;
      issues = 0;
      for (int cyc = 0; cyc < 60 && !(m1Sent == 12 && m0Done); cyc++) begin
         @(negedge clk);
         reset         = 1'b0;
         s_readdata    = 32'h0;
         m1_chipselect = (m1Sent < 12);
         m1_write_n    = 1'b0;
         m1_lock       = (m1Sent < 11);
         m1_address    = 3'd0;
         m1_writedata  = 32'(m1Sent);
         m0_chipselect = (cyc > 0) && !m0Done;
         m0_write_n    = 1'b0;
         m0_lock       = 1'b0;
         m0_address    = 3'd1;
         m0_writedata  = 32'h77;
         #1;
         if (s_chipselect) begin
            if (issues < 13) begin
               check($sformatf("lock_issue%0d/s_address", issues), 32'(s_address), 32'(expAddr[issues]));
               check($sformatf("lock_issue%0d/s_writedata", issues), s_writedata, expData[issues]);
            end
            issues++;
         end
         if (m1_chipselect && !m1_waitrequest) m1Sent++;
         if (m0_chipselect && !m0_waitrequest) m0Done = 1'b1;
      end
      check("lock_issue_count", 32'(issues), 32'd13);

      idleVec.rst = 1'b0;
      runVector(idleVec, "post_lock_idle");

      for (int i = 0; i < 5; i++)
         runVector(rstSeq[i], $sformatf("rst_read%0d", i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
